// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-PC unit: execute-stage mode encodings
// and default datapath parameters.
package next_pc_unit_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    // 1xx encodings are reserved and decode as MODE_NONE.
    typedef enum logic [2:0] {
        MODE_NONE   = 3'b000,
        MODE_JAL    = 3'b001,
        MODE_JALR   = 3'b010,
        MODE_BRANCH = 3'b011
    } ex_mode_e;

endpackage

// File: rtl/next_pc_unit_if.sv
// Execute-stage control-transfer bundle presented to the next-PC unit.
//
// Handshake: ex_valid qualifies every other field of the bundle. There is no
// ready; the unit accepts each valid transfer in the cycle it is presented,
// and a fetch stall only defers the effect of that transfer on the PC.
interface next_pc_unit_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic [2:0]      ex_mode;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1;
    logic            br_taken;

    modport master (
        output ex_valid, ex_mode, ex_pc, ex_imm, ex_rs1, br_taken
    );

    modport slave (
        input ex_valid, ex_mode, ex_pc, ex_imm, ex_rs1, br_taken
    );
endinterface

// File: rtl/npc_target_calc.sv
// Combinational execute-stage target: computes the jump/branch address and
// splits a taken transfer into either a redirect or a misalignment event.
module npc_target_calc
    import next_pc_unit_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int IALIGN = 32
) (
    input  logic            ex_valid,
    input  logic [2:0]      ex_mode,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            br_taken,
    output logic [XLEN-1:0] target,
    output logic            ex_redirect,
    output logic            misaligned
);

    localparam logic CHECK_BIT1 = (IALIGN == 32);

    logic taken;
    logic bad_align;

    always_comb begin
        target = '0;
        taken  = 1'b0;
        case (ex_mode)
            MODE_JAL: begin
                target = ex_pc + ex_imm;
                taken  = 1'b1;
            end
            MODE_BRANCH: begin
                target = ex_pc + ex_imm;
                taken  = br_taken;
            end
            MODE_JALR: begin
                target = (ex_rs1 + ex_imm) & ~XLEN'(1);
                taken  = 1'b1;
            end
            default: begin
                target = '0;
                taken  = 1'b0;
            end
        endcase

        // JALR always clears bit0, so only JAL/BRANCH can trip the bit0 test.
        bad_align   = target[0] | (CHECK_BIT1 & target[1]);
        ex_redirect = ex_valid & taken & ~bad_align;
        misaligned  = ex_valid & taken & bad_align;
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with prioritised redirect selection (trap, MRET, execute),
// a one-deep redirect hold across fetch stalls, and misaligned-target reporting.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int              IALIGN       = 32,
    parameter int              PC_STEP      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    next_pc_unit_if.slave     ex,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   mtvec,
    input  logic              mret_req,
    input  logic [XLEN-1:0]   mepc,
    output logic [XLEN-1:0]   pc_o,
    output logic              redirect_o,
    output logic              pending_o,
    output logic              misalign_o,
    output logic [XLEN-1:0]   misalign_addr_o
);

    logic [XLEN-1:0] ex_target;
    logic            ex_redirect;
    logic            ex_misaligned;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            pending_q, pending_d;
    logic            mis_q;
    logic [XLEN-1:0] mis_addr_q;

    logic            redirect;
    logic [XLEN-1:0] redirect_tgt;

    npc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_calc (
        .ex_valid    (ex.ex_valid),
        .ex_mode     (ex.ex_mode),
        .ex_pc       (ex.ex_pc),
        .ex_imm      (ex.ex_imm),
        .ex_rs1      (ex.ex_rs1),
        .br_taken    (ex.br_taken),
        .target      (ex_target),
        .ex_redirect (ex_redirect),
        .misaligned  (ex_misaligned)
    );

    always_comb begin
        redirect     = trap_req | mret_req | ex_redirect;
        redirect_tgt = ex_target;
        if (trap_req) begin
            redirect_tgt = mtvec;
        end else if (mret_req) begin
            redirect_tgt = mepc;
        end

        pc_d       = pc_q;
        pending_d  = 1'b0;
        pend_tgt_d = pend_tgt_q;
        if (stall) begin
            // A newer redirect replaces whatever is held; trap wins via redirect_tgt.
            pending_d = pending_q | redirect;
            if (redirect) begin
                pend_tgt_d = redirect_tgt;
            end
        end else if (redirect) begin
            pc_d = redirect_tgt;
        end else if (pending_q) begin
            pc_d = pend_tgt_q;
        end else begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            pend_tgt_q <= '0;
            pending_q  <= 1'b0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pending_q  <= pending_d;
            mis_q      <= ex_misaligned;
            if (ex_misaligned) begin
                mis_addr_q <= ex_target;
            end
        end
    end

    assign pc_o            = pc_q;
    assign redirect_o      = rst_n & redirect;
    assign pending_o       = pending_q;
    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: two instances (IALIGN 32 and 16) share one
// stimulus stream; a per-cycle expected record is queued and checked mid-cycle.
module tb_next_pc_unit;
    import next_pc_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int W    = 4 * XLEN + 6;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            stall;
    logic            trap_req;
    logic            mret_req;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;

    next_pc_unit_if #(.XLEN(XLEN)) ex_bus ();

    logic [XLEN-1:0] pc32, pc16, ma32, ma16;
    logic            r32, r16, p32, p16, m32, m16;

    next_pc_unit #(.XLEN(XLEN), .IALIGN(32)) dut32 (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .ex              (ex_bus),
        .trap_req        (trap_req),
        .mtvec           (mtvec),
        .mret_req        (mret_req),
        .mepc            (mepc),
        .pc_o            (pc32),
        .redirect_o      (r32),
        .pending_o       (p32),
        .misalign_o      (m32),
        .misalign_addr_o (ma32)
    );

    next_pc_unit #(.XLEN(XLEN), .IALIGN(16)) dut16 (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .ex              (ex_bus),
        .trap_req        (trap_req),
        .mtvec           (mtvec),
        .mret_req        (mret_req),
        .mepc            (mepc),
        .pc_o            (pc16),
        .redirect_o      (r16),
        .pending_o       (p16),
        .misalign_o      (m16),
        .misalign_addr_o (ma16)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc32",      pc32,           e[133:102]);
            check("pc16",      pc16,           e[101:70]);
            check("maddr32",   ma32,           e[69:38]);
            check("maddr16",   ma16,           e[37:6]);
            check("redir32",   XLEN'(r32),     XLEN'(e[5]));
            check("redir16",   XLEN'(r16),     XLEN'(e[4]));
            check("pend32",    XLEN'(p32),     XLEN'(e[3]));
            check("pend16",    XLEN'(p16),     XLEN'(e[3]));
            check("misalign32", XLEN'(m32),    XLEN'(e[2]));
            check("misalign16", XLEN'(m16),    XLEN'(e[1]));
        end
    end

    // driver tasks
    task automatic idle();
        stall           = 1'b0;
        trap_req        = 1'b0;
        mret_req        = 1'b0;
        mtvec           = '0;
        mepc            = '0;
        ex_bus.ex_valid = 1'b0;
        ex_bus.ex_mode  = MODE_NONE;
        ex_bus.ex_pc    = '0;
        ex_bus.ex_imm   = '0;
        ex_bus.ex_rs1   = '0;
        ex_bus.br_taken = 1'b0;
    endtask

    task automatic set_ex(input logic [2:0] mode, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1,
                          input logic taken);
        ex_bus.ex_valid = 1'b1;
        ex_bus.ex_mode  = mode;
        ex_bus.ex_pc    = pc;
        ex_bus.ex_imm   = imm;
        ex_bus.ex_rs1   = rs1;
        ex_bus.br_taken = taken;
    endtask

    // Queue this cycle's expected outputs, then advance to just past the next edge.
    task automatic step(input logic [XLEN-1:0] e_pc32, input logic [XLEN-1:0] e_pc16,
                        input logic [XLEN-1:0] e_ma32, input logic [XLEN-1:0] e_ma16,
                        input logic e_r32, input logic e_r16, input logic e_pend,
                        input logic e_m32, input logic e_m16);
        exp_q.push_back({e_pc32, e_pc16, e_ma32, e_ma16, e_r32, e_r16, e_pend, e_m32, e_m16, 1'b0});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // reset: trap request must not leak to redirect_o
        trap_req = 1'b1; mtvec = 32'h80;
        step(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);

        // sequential fetch
        idle(); rst_n = 1'b1;
        step(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        step(32'h4, 32'h4, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        step(32'h8, 32'h8, 32'h0, 32'h0, 0, 0, 0, 0, 0);

        // JAL with negative offset
        set_ex(MODE_JAL, 32'h100, 32'hFFFF_FFF0, 32'h0, 1'b0);
        step(32'hC, 32'hC, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        idle();
        step(32'hF0, 32'hF0, 32'h0, 32'h0, 0, 0, 0, 0, 0);

        // JALR to 0x202: misaligned for IALIGN=32, legal for IALIGN=16
        set_ex(MODE_JALR, 32'h0, 32'h0, 32'h203, 1'b0);
        step(32'hF4, 32'hF4, 32'h0, 32'h0, 0, 1, 0, 0, 0);
        idle();
        step(32'hF8, 32'h202, 32'h202, 32'h0, 0, 0, 0, 1, 0);

        // JAL to odd target: misaligned for both
        set_ex(MODE_JAL, 32'h100, 32'h1, 32'h0, 1'b0);
        step(32'hFC, 32'h206, 32'h202, 32'h0, 0, 0, 0, 0, 0);

        // trap beats mret beats JAL
        idle();
        trap_req = 1'b1; mtvec = 32'h80; mret_req = 1'b1; mepc = 32'h1234;
        set_ex(MODE_JAL, 32'h100, 32'h10, 32'h0, 1'b0);
        step(32'h100, 32'h20A, 32'h101, 32'h101, 1, 1, 0, 1, 1);
        idle();
        mret_req = 1'b1; mepc = 32'h1234;
        step(32'h80, 32'h80, 32'h101, 32'h101, 1, 1, 0, 0, 0);
        idle();
        step(32'h1234, 32'h1234, 32'h101, 32'h101, 0, 0, 0, 0, 0);

        // taken branch under a 3-cycle stall, then release
        stall = 1'b1;
        set_ex(MODE_BRANCH, 32'h300, 32'h100, 32'h0, 1'b1);
        step(32'h1238, 32'h1238, 32'h101, 32'h101, 1, 1, 0, 0, 0);
        idle(); stall = 1'b1;
        step(32'h1238, 32'h1238, 32'h101, 32'h101, 0, 0, 1, 0, 0);
        set_ex(MODE_BRANCH, 32'h300, 32'h100, 32'h0, 1'b0);
        step(32'h1238, 32'h1238, 32'h101, 32'h101, 0, 0, 1, 0, 0);
        idle();
        step(32'h1238, 32'h1238, 32'h101, 32'h101, 0, 0, 1, 0, 0);
        step(32'h400, 32'h400, 32'h101, 32'h101, 0, 0, 0, 0, 0);

        // held redirect overwritten, then a new redirect wins at release
        stall = 1'b1;
        set_ex(MODE_JAL, 32'h500, 32'h0, 32'h0, 1'b0);
        step(32'h404, 32'h404, 32'h101, 32'h101, 1, 1, 0, 0, 0);
        set_ex(MODE_JAL, 32'h600, 32'h0, 32'h0, 1'b0);
        step(32'h404, 32'h404, 32'h101, 32'h101, 1, 1, 1, 0, 0);
        stall = 1'b0;
        set_ex(MODE_JAL, 32'h700, 32'h4, 32'h0, 1'b0);
        step(32'h404, 32'h404, 32'h101, 32'h101, 1, 1, 1, 0, 0);

        // reserved mode is no redirect
        idle();
        set_ex(3'b100, 32'h100, 32'h100, 32'h100, 1'b1);
        step(32'h704, 32'h704, 32'h101, 32'h101, 0, 0, 0, 0, 0);

        // pending at 0x400, then reset mid-stall
        idle(); stall = 1'b1;
        set_ex(MODE_BRANCH, 32'h3F0, 32'h10, 32'h0, 1'b1);
        step(32'h708, 32'h708, 32'h101, 32'h101, 1, 1, 0, 0, 0);
        idle(); stall = 1'b1;
        step(32'h708, 32'h708, 32'h101, 32'h101, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        step(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        rst_n = 1'b1; stall = 1'b0;
        step(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);

        // PC wrap at the top of the address space
        trap_req = 1'b1; mtvec = 32'hFFFF_FFFC;
        step(32'h4, 32'h4, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        idle();
        step(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        step(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);

        // JALR sum wraps and bit0 is cleared: 0xFFFFFFFF + 9 -> 0x8
        set_ex(MODE_JALR, 32'h0, 32'h9, 32'hFFFF_FFFF, 1'b0);
        step(32'h4, 32'h4, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        idle();
        step(32'h8, 32'h8, 32'h0, 32'h0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
